ram_arb2: RTL and testbench
===========================

RAM_ARB2 -- requirements
Module: ram_arb2

Interface
REQ-001 Parameter AW, default 4, RAM address width.
REQ-002 Parameter DW, default 4, RAM data width.
REQ-003 Parameter MAXLOCK, default 8, maximum consecutive locked grants to one requester (range 1..255).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RSTN  input  1  reset, asynchronous assert, active-low.
REQ-006 REQ  input  2  per-requester access request; bit n = requester n.
REQ-007 WR  input  2  per-requester command, 1 = write, 0 = read; valid while REQ[n]=1.
REQ-008 LOCK  input  2  per-requester request to keep ownership for following accesses.
REQ-009 A  input  2*AW  addresses; requester n at [n*AW +: AW].
REQ-010 D  input  2*DW  write data; requester n at [n*DW +: DW].
REQ-011 ACK  output  2  one-hot-or-zero; ACK[n]=1 marks the cycle requester n's access is issued.
REQ-012 RVALID  output  2  read data valid for requester n.
REQ-013 RDATA  output  DW  read data, shared; meaningful only when RVALID[n]=1.
REQ-014 RAM_EN, RAM_WR  output  1 each  RAM enable and write command (1 write, 0 read).
REQ-015 RAM_A  output  AW; RAM_D  output  DW  RAM address and write data.
REQ-016 RAM_Q  input  DW  RAM read data, valid the cycle after a read is sampled.

Function
REQ-017 Access issue SHALL be combinational: in the grant cycle, ACK[n]=1, RAM_EN=1, RAM_WR=WR[n], RAM_A/RAM_D = requester n's slices.
REQ-018 With no grant, ACK=0, RAM_EN=0, RAM_WR=0, RAM_A=0, RAM_D=0.
REQ-019 Requester holds REQ/WR/A/D stable until it sees ACK; one access per ACK cycle; back-to-back accesses allowed, one per cycle.
REQ-020 FSM states IDLE, LOCK0, LOCK1.
REQ-021 IDLE: grant the single requester if only one REQ bit set; if both, grant requester PTR.
REQ-022 IDLE, grant to n with LOCK[n]=1 -> LOCKn, lock counter CNT=1; with LOCK[n]=0 -> stay IDLE, PTR = 1-n.
REQ-023 LOCKn: only requester n is granted; the other requester waits regardless of REQ.
REQ-024 LOCKn exit to IDLE with PTR = 1-n when REQ[n]=0, or a grant occurs with LOCK[n]=0, or a grant occurs with CNT = MAXLOCK-1 (forced release); else CNT increments on each grant.
REQ-025 Forced release SHALL still issue the access in that cycle; the next grant to n needs a fresh arbitration.
REQ-026 MAXLOCK=1 SHALL make LOCK ineffective (every grant returns to IDLE).
REQ-027 Read latency: RVALID[n] registered, asserted exactly one cycle after a read ACK[n], for one cycle per read; RDATA = RAM_Q in that cycle.
REQ-028 Writes SHALL produce no RVALID.
REQ-029 RVALID from a read and a new ACK to either requester in the same cycle SHALL be supported.

Reset
REQ-030 RSTN low SHALL immediately force state IDLE, PTR=0, CNT=0, RVALID=0.
REQ-031 A read issued in the cycle reset asserts SHALL produce no RVALID; arbitration resumes on the first edge after RSTN rises.

Structure
REQ-032 Shared package ram_arb_pkg holds the FSM state enum (IDLE, LOCK0, LOCK1) and the default AW/DW/MAXLOCK constants.
REQ-033 Sub-module rr_pick2 (two requests + PTR -> one-hot grant) is the natural combinational split; FSM, counter and RVALID pipeline stay in ram_arb2.
REQ-034 Bench instantiates ram_arb2 with the team's ram model (AW=4, DW=4) on the RAM side.

Verification
REQ-035 Only REQ[0], write A=3 D=5, then read A=3 -> ACK[0] both cycles, RVALID[0] one cycle after read ACK, RDATA=5.
REQ-036 Both REQ held, LOCK=0, reads -> ACK alternates 0,1,0,1 starting with requester 0 after reset.
REQ-037 REQ[1]+LOCK[1] held, REQ[0] held, MAXLOCK=8 -> eight consecutive ACK[1], then ACK[0] next cycle.
REQ-038 LOCK0, requester 0 drops REQ while REQ[1] pending -> ACK[1] in the following cycle, state IDLE.
REQ-039 RSTN pulsed low during the cycle of a read ACK[1] -> RVALID stays 0, PTR=0, state IDLE after release.
REQ-040 Simultaneous RVALID[0] and write ACK[1] same cycle -> RDATA correct, write lands at given address (verified by later read).

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared definitions for the two-requester RAM arbiter:
//               arbiter FSM state encoding and default geometry/lock limit.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

  // Default RAM address width, data width and lock-burst limit
  localparam int c_def_aw      = 4;
  localparam int c_def_dw      = 4;
  localparam int c_def_maxlock = 8;

  // Arbiter FSM states: open arbitration, or ownership held by requester 0/1
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arb2_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin pick. Grants the only active request, or
//               the request selected by the pointer when both are active.
// Ports       : i_req [1:0]  request vector
//               i_ptr        preferred requester on contention
//               o_gnt [1:0]  one-hot-or-zero grant
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_ptr ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule : rr_pick2
`default_nettype wire

// File: rtl/ram_arb2.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb2
// Description : Two-requester single-port RAM arbiter with round-robin
//               fairness, bounded lock bursts and a one-cycle read return.
// Ports       : i_clk, i_rstn          clock / async active-low reset
//               i_req, i_wr, i_lock    per-requester request/command/lock
//               i_a, i_d               packed per-requester address/data
//               o_ack                  access issued this cycle (one-hot)
//               o_rvalid, o_rdata      read return, one cycle after read ack
//               o_ram_en/wr/a/d        RAM command side
//               i_ram_q                RAM read data
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arb2
  import ram_arb_pkg::*;
#(
  parameter int AW      = c_def_aw,
  parameter int DW      = c_def_dw,
  parameter int MAXLOCK = c_def_maxlock
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [1:0]      i_req,
  input  logic [1:0]      i_wr,
  input  logic [1:0]      i_lock,
  input  logic [2*AW-1:0] i_a,
  input  logic [2*DW-1:0] i_d,
  output logic [1:0]      o_ack,
  output logic [1:0]      o_rvalid,
  output logic [DW-1:0]   o_rdata,
  output logic            o_ram_en,
  output logic            o_ram_wr,
  output logic [AW-1:0]   o_ram_a,
  output logic [DW-1:0]   o_ram_d,
  input  logic [DW-1:0]   i_ram_q
);

  // With MAXLOCK=1 a lock could never outlast its first grant, so the
  // arbiter simply never leaves IDLE.
  localparam bit        c_lock_en  = (MAXLOCK > 1);
  localparam logic [7:0] c_cnt_last = 8'(MAXLOCK - 1);

  arb_state_t r_state, w_state_nxt;
  logic       r_ptr,   w_ptr_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;
  logic [1:0] r_rvalid;
  logic [1:0] w_pick;
  logic [1:0] w_gnt;

  rr_pick2 u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state  <= IDLE;
      r_ptr    <= 1'b0;
      r_cnt    <= 8'd0;
      r_rvalid <= 2'b00;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= w_gnt & ~i_wr;
    end
  end

  always_comb begin
    w_gnt       = 2'b00;
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_gnt = w_pick;
        if (w_gnt[0]) begin
          if (i_lock[0] && c_lock_en) begin
            w_state_nxt = LOCK0;
            w_cnt_nxt   = 8'd1;
          end else begin
            w_ptr_nxt = 1'b1;
          end
        end else if (w_gnt[1]) begin
          if (i_lock[1] && c_lock_en) begin
            w_state_nxt = LOCK1;
            w_cnt_nxt   = 8'd1;
          end else begin
            w_ptr_nxt = 1'b0;
          end
        end
      end
      LOCK0: begin
        // Owner only; the other requester waits even if requesting.
        w_gnt = {1'b0, i_req[0]};
        if (!i_req[0] || !i_lock[0] || (r_cnt == c_cnt_last)) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = 1'b1;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      LOCK1: begin
        w_gnt = {i_req[1], 1'b0};
        if (!i_req[1] || !i_lock[1] || (r_cnt == c_cnt_last)) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = 1'b0;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // RAM command mux: all-zero when nothing is granted
  always_comb begin
    o_ram_en = 1'b0;
    o_ram_wr = 1'b0;
    o_ram_a  = '0;
    o_ram_d  = '0;
    if (w_gnt[0]) begin
      o_ram_en = 1'b1;
      o_ram_wr = i_wr[0];
      o_ram_a  = i_a[0 +: AW];
      o_ram_d  = i_d[0 +: DW];
    end else if (w_gnt[1]) begin
      o_ram_en = 1'b1;
      o_ram_wr = i_wr[1];
      o_ram_a  = i_a[AW +: AW];
      o_ram_d  = i_d[DW +: DW];
    end
  end

  assign o_ack    = w_gnt;
  assign o_rvalid = r_rvalid;
  assign o_rdata  = i_ram_q;

endmodule : ram_arb2
`default_nettype wire

// File: tb/tb_ram_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arb2
// Description : Directed self-checking bench for ram_arb2 with a synchronous
//               16x4 RAM model on the RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arb2;
  import ram_arb_pkg::*;

  logic       clk;
  logic       rstn;
  logic [1:0] req, wr, lock;
  logic [7:0] a, d;
  logic [1:0] ack, rvalid;
  logic [3:0] rdata;
  logic       ram_en, ram_wr;
  logic [3:0] ram_a, ram_d, ram_q;

  int n_checks = 0;
  int n_err    = 0;

  ram_arb2 #(.AW(4), .DW(4), .MAXLOCK(8)) dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_req    (req),
    .i_wr     (wr),
    .i_lock   (lock),
    .i_a      (a),
    .i_d      (d),
    .o_ack    (ack),
    .o_rvalid (rvalid),
    .o_rdata  (rdata),
    .o_ram_en (ram_en),
    .o_ram_wr (ram_wr),
    .o_ram_a  (ram_a),
    .o_ram_d  (ram_d),
    .i_ram_q  (ram_q)
  );

  // Synchronous RAM: write on enable+write, read data registered
  logic [3:0] mem [16];
  always_ff @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) mem[ram_a] <= ram_d;
      else        ram_q      <= mem[ram_a];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling
  task automatic settle();
    #3;
  endtask

  initial begin
    rstn = 1'b0; req = 2'b00; wr = 2'b00; lock = 2'b00; a = 8'h00; d = 8'h00;
    tick();
    settle();
    chk("rst_ack",    32'(ack),    32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    rstn = 1'b1;

    // Requester 0 alone: write A=3 D=5, then read it back
    tick();
    req = 2'b01; wr = 2'b01; a = 8'h03; d = 8'h05;
    settle();
    chk("wr0_ack",  32'(ack),    32'h1);
    chk("wr0_en",   32'(ram_en), 32'h1);
    chk("wr0_wr",   32'(ram_wr), 32'h1);
    chk("wr0_a",    32'(ram_a),  32'h3);
    chk("wr0_d",    32'(ram_d),  32'h5);
    tick();
    chk("wr_no_rvalid", 32'(rvalid), 32'h0);
    wr = 2'b00;
    settle();
    chk("rd0_ack", 32'(ack),    32'h1);
    chk("rd0_wr",  32'(ram_wr), 32'h0);
    tick();
    req = 2'b00; d = 8'h00;
    chk("rd0_rvalid", 32'(rvalid), 32'h1);
    chk("rd0_rdata",  32'(rdata),  32'h5);
    settle();
    chk("idle_ack",   32'(ack),    32'h0);
    chk("idle_ram_a", 32'(ram_a),  32'h0);
    chk("idle_ram_d", 32'(ram_d),  32'h0);

    // Fresh reset, then both reading without lock: 0,1,0,1
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    tick();
    req = 2'b11; wr = 2'b00; a = 8'h33;
    settle();
    chk("rr_ack0", 32'(ack), 32'h1);
    tick();
    chk("rr_rvalid0", 32'(rvalid), 32'h1);
    settle();
    chk("rr_ack1", 32'(ack), 32'h2);
    tick();
    chk("rr_rvalid1", 32'(rvalid), 32'h2);
    settle();
    chk("rr_ack2", 32'(ack), 32'h1);
    tick();
    settle();
    chk("rr_ack3", 32'(ack), 32'h2);

    // Requester 1 locks: eight grants to 1, then requester 0
    tick();
    req = 2'b10; lock = 2'b10;
    settle();
    chk("lk_ack_first", 32'(ack), 32'h2);
    for (int i = 0; i < 7; i++) begin
      tick();
      req = 2'b11;
      settle();
      chk("lk_ack_burst", 32'(ack), 32'h2);
    end
    tick();
    settle();
    chk("lk_forced_release", 32'(ack), 32'h1);
    tick();
    req = 2'b00; lock = 2'b00;

    // Requester 0 locks, then drops its request while 1 waits
    req = 2'b01; lock = 2'b01;
    settle();
    chk("l0_ack_first", 32'(ack), 32'h1);
    tick();
    req = 2'b11;
    settle();
    chk("l0_hold", 32'(ack), 32'h1);
    tick();
    req = 2'b10; lock = 2'b00;
    settle();
    chk("l0_drop_ack", 32'(ack), 32'h0);
    tick();
    settle();
    chk("l0_other_ack", 32'(ack), 32'h2);
    tick();
    req = 2'b00;
    chk("l0_state_idle", 32'(dut.r_state), 32'(IDLE));

    // Read by 0 returns in the same cycle as a write by 1
    req = 2'b01; wr = 2'b00; a = 8'h63;
    settle();
    chk("mix_rd_ack", 32'(ack), 32'h1);
    tick();
    req = 2'b10; wr = 2'b10; d = 8'hA0;
    chk("mix_rvalid", 32'(rvalid), 32'h1);
    chk("mix_rdata",  32'(rdata),  32'h5);
    settle();
    chk("mix_wr_ack", 32'(ack),    32'h2);
    chk("mix_wr_a",   32'(ram_a),  32'h6);
    chk("mix_wr_d",   32'(ram_d),  32'hA);
    tick();
    wr = 2'b00;
    chk("mix_wr_no_rvalid", 32'(rvalid), 32'h0);
    settle();
    chk("mix_rd1_ack", 32'(ack), 32'h2);
    tick();
    req = 2'b00;
    chk("mix_rd1_rvalid", 32'(rvalid), 32'h2);
    chk("mix_rd1_rdata",  32'(rdata),  32'hA);

    // Reset asserted during a read grant to requester 1
    req = 2'b10; wr = 2'b00;
    settle();
    chk("rstrd_ack", 32'(ack), 32'h2);
    rstn = 1'b0;
    tick();
    chk("rstrd_rvalid", 32'(rvalid), 32'h0);
    rstn = 1'b1;
    req = 2'b11;
    chk("rstrd_state", 32'(dut.r_state), 32'(IDLE));
    settle();
    chk("rstrd_ptr0_ack", 32'(ack), 32'h1);
    tick();
    req = 2'b00;
    chk("rstrd_resume_rvalid", 32'(rvalid), 32'h1);
    chk("rstrd_resume_rdata",  32'(rdata),  32'h5);

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_ram_arb2
`default_nettype wire
